// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
// Negation helpers work on a 64-bit carrier, so WIDTH is limited to 64.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } div_state_e;

  localparam int DIV_WIDTH = 32;
  localparam int CNT_W     = $clog2(DIV_WIDTH + 1);
  localparam int MAX_W     = 64;

  function automatic logic [MAX_W-1:0] negate(input logic [MAX_W-1:0] x);
    return ~x + MAX_W'(1);
  endfunction

  function automatic logic [MAX_W-1:0] cond_negate(input logic [MAX_W-1:0] x,
                                                   input logic             neg);
    return neg ? negate(x) : x;
  endfunction

  // Magnitude of a value whose sign the caller has already decoded.
  function automatic logic [MAX_W-1:0] abs_val(input logic [MAX_W-1:0] x,
                                               input logic             is_neg);
    return cond_negate(x, is_neg);
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring iteration: shift {rem,quo} left one bit and
// keep the trial difference when it does not go negative.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic fits;

  // The shifted partial remainder needs WIDTH+1 bits before the subtract.
  assign fits     = ({rem, quo[WIDTH-1]} >= {1'b0, divisor});
  assign rem_next = fits ? WIDTH'({rem, quo[WIDTH-1]} - {1'b0, divisor})
                         : {rem[WIDTH-2:0], quo[WIDTH-1]};
  assign quo_next = {quo[WIDTH-2:0], fits};

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed/unsigned integer divider, one quotient bit per clock.
// Optional DIV_FAST_EXIT_EN skips iteration when |dividend| < |divisor|.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int CNT_BITS = $clog2(WIDTH + 1);

  div_state_e          state_reg, state_next;
  logic [CNT_BITS-1:0] cnt_reg, cnt_next;
  logic [WIDTH-1:0]    rem_reg, rem_next;
  logic [WIDTH-1:0]    quo_reg, quo_next;
  logic [WIDTH-1:0]    dsr_reg, dsr_next;
  logic                neg_q_reg, neg_q_next;
  logic                neg_r_reg, neg_r_next;
  logic                dz_reg, dz_next;
  logic                done_reg, done_next;
  logic                div_zero_reg, div_zero_next;
  logic [WIDTH-1:0]    quotient_reg, quotient_next;
  logic [WIDTH-1:0]    remainder_reg, remainder_next;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic             fast_exit;
  logic [WIDTH-1:0] step_rem, step_quo;

  assign a_neg = is_signed & dividend[WIDTH-1];
  assign b_neg = is_signed & divisor[WIDTH-1];
  assign a_abs = WIDTH'(abs_val(MAX_W'(dividend), a_neg));
  assign b_abs = WIDTH'(abs_val(MAX_W'(divisor), b_neg));

`ifdef DIV_FAST_EXIT_EN
  assign fast_exit = (a_abs < b_abs);
`else
  assign fast_exit = 1'b0;
`endif

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem     (rem_reg),
    .quo     (quo_reg),
    .divisor (dsr_reg),
    .rem_next(step_rem),
    .quo_next(step_quo)
  );

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    rem_next       = rem_reg;
    quo_next       = quo_reg;
    dsr_next       = dsr_reg;
    neg_q_next     = neg_q_reg;
    neg_r_next     = neg_r_reg;
    dz_next        = dz_reg;
    done_next      = 1'b0;
    div_zero_next  = div_zero_reg;
    quotient_next  = quotient_reg;
    remainder_next = remainder_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          cnt_next      = CNT_BITS'(WIDTH);
          dsr_next      = b_abs;
          neg_q_next    = a_neg ^ b_neg;
          neg_r_next    = a_neg;
          div_zero_next = 1'b0;
          dz_next       = 1'b0;
          if (divisor == '0) begin
            // Preload the divide-by-zero results so FIN needs no special case.
            dz_next    = 1'b1;
            rem_next   = dividend;
            quo_next   = '1;
            neg_q_next = 1'b0;
            neg_r_next = 1'b0;
            state_next = FIN;
          end else if (fast_exit) begin
            rem_next   = a_abs;
            quo_next   = '0;
            state_next = FIN;
          end else begin
            rem_next   = '0;
            quo_next   = a_abs;
            state_next = RUN;
          end
        end
      end

      RUN: begin
        rem_next = step_rem;
        quo_next = step_quo;
        cnt_next = cnt_reg - CNT_BITS'(1);
        if (cnt_reg == CNT_BITS'(1)) begin
          state_next = FIN;
        end
      end

      FIN: begin
        quotient_next  = WIDTH'(cond_negate(MAX_W'(quo_reg), neg_q_reg));
        remainder_next = WIDTH'(cond_negate(MAX_W'(rem_reg), neg_r_reg));
        div_zero_next  = dz_reg;
        done_next      = 1'b1;
        state_next     = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      rem_reg       <= '0;
      quo_reg       <= '0;
      dsr_reg       <= '0;
      neg_q_reg     <= 1'b0;
      neg_r_reg     <= 1'b0;
      dz_reg        <= 1'b0;
      done_reg      <= 1'b0;
      div_zero_reg  <= 1'b0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      rem_reg       <= rem_next;
      quo_reg       <= quo_next;
      dsr_reg       <= dsr_next;
      neg_q_reg     <= neg_q_next;
      neg_r_reg     <= neg_r_next;
      dz_reg        <= dz_next;
      done_reg      <= done_next;
      div_zero_reg  <= div_zero_next;
      quotient_reg  <= quotient_next;
      remainder_reg <= remainder_next;
    end
  end

  assign busy      = (state_reg != IDLE);
  assign done      = done_reg;
  assign quotient  = quotient_reg;
  assign remainder = remainder_reg;
  assign div_zero  = div_zero_reg;

endmodule
